// File: rtl/bottle_print_pkg.sv
// Shared types and widths for the bottle print sequencer.
// Holds the sequencer state encoding and the per-bottle configuration clamp.
package bottle_print_pkg;

  localparam int ROAD_W = 8;
  localparam int CYC_W  = 8;
  localparam int CNT_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    PRINT = 1'b1
  } bp_state_e;

  // A programmed count of 0 behaves as 1, so the terminal index is 0 in both cases.
  function automatic logic [7:0] cfg_max(input logic [7:0] n);
    return (n == 8'd0) ? 8'd0 : n - 8'd1;
  endfunction

endpackage

// File: rtl/bottle_print_if.sv
// Configuration, strobe and status bundle between the line controller and bottle_print.
interface bottle_print_if;
  import bottle_print_pkg::*;

  logic              dianyan_en;
  logic              b_p_clr;
  logic              valid_edge_f1;
  logic [ROAD_W-1:0] b_p_road_num;
  logic [CYC_W-1:0]  b_p_cycle_num;
  logic              b_p_busy;
  logic              b_p_fire;
  logic [ROAD_W-1:0] b_p_fire_road;
  logic [CYC_W-1:0]  b_p_fire_cycle;
  logic              b_p_done;
  logic [CNT_W-1:0]  b_p_bottle_cnt;
  logic              b_p_overrun;

  modport master (
    output dianyan_en, b_p_clr, valid_edge_f1, b_p_road_num, b_p_cycle_num,
    input  b_p_busy, b_p_fire, b_p_fire_road, b_p_fire_cycle, b_p_done,
           b_p_bottle_cnt, b_p_overrun
  );

  modport slave (
    input  dianyan_en, b_p_clr, valid_edge_f1, b_p_road_num, b_p_cycle_num,
    output b_p_busy, b_p_fire, b_p_fire_road, b_p_fire_cycle, b_p_done,
           b_p_bottle_cnt, b_p_overrun
  );

endinterface

// File: rtl/bp_edge_sync.sv
// Two-flop synchronizer plus delayed copy; flags a high-to-low transition of an async level.
// All flops reset high so an idle-high input never produces a trigger on reset release.
module bp_edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign fall_o = s3_q & ~s2_q;

endmodule

// File: rtl/bottle_print.sv
// Per-bottle print sequencer: photo-eye trigger starts a bottle, each print-position
// strobe fires one road; roads and cycles come from the configuration latched at trigger.
module bottle_print
  import bottle_print_pkg::*;
(
  input  logic               clk_100,
  input  logic               nRST,
  bottle_print_if.slave      bus
);

  logic eye_trig;

  bp_edge_sync u_eye (
    .clk_i   (clk_100),
    .rst_n_i (nRST),
    .async_i (bus.dianyan_en),
    .fall_o  (eye_trig)
  );

  bp_state_e         state_q, state_d;
  logic [ROAD_W-1:0] road_max_q, road_max_d;
  logic [CYC_W-1:0]  cyc_max_q, cyc_max_d;
  logic [ROAD_W-1:0] road_idx_q, road_idx_d;
  logic [CYC_W-1:0]  cyc_idx_q, cyc_idx_d;
  logic              fire_q, fire_d;
  logic [ROAD_W-1:0] fire_road_q, fire_road_d;
  logic [CYC_W-1:0]  fire_cyc_q, fire_cyc_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overrun_q, overrun_d;

  always_ff @(posedge clk_100 or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      road_max_q  <= '0;
      cyc_max_q   <= '0;
      road_idx_q  <= '0;
      cyc_idx_q   <= '0;
      fire_q      <= 1'b0;
      fire_road_q <= '0;
      fire_cyc_q  <= '0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      road_max_q  <= road_max_d;
      cyc_max_q   <= cyc_max_d;
      road_idx_q  <= road_idx_d;
      cyc_idx_q   <= cyc_idx_d;
      fire_q      <= fire_d;
      fire_road_q <= fire_road_d;
      fire_cyc_q  <= fire_cyc_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    road_max_d  = road_max_q;
    cyc_max_d   = cyc_max_q;
    road_idx_d  = road_idx_q;
    cyc_idx_d   = cyc_idx_q;
    fire_d      = 1'b0;
    fire_road_d = fire_road_q;
    fire_cyc_d  = fire_cyc_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;

    if (bus.b_p_clr) begin
      state_d     = IDLE;
      road_max_d  = '0;
      cyc_max_d   = '0;
      road_idx_d  = '0;
      cyc_idx_d   = '0;
      fire_road_d = '0;
      fire_cyc_d  = '0;
      cnt_d       = '0;
      overrun_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (eye_trig) begin
            state_d    = PRINT;
            road_max_d = cfg_max(bus.b_p_road_num);
            cyc_max_d  = cfg_max(bus.b_p_cycle_num);
            road_idx_d = '0;
            cyc_idx_d  = '0;
          end
        end
        PRINT: begin
          // A second bottle while printing is only flagged; the current one runs to completion.
          if (eye_trig) overrun_d = 1'b1;
          if (bus.valid_edge_f1) begin
            fire_d      = 1'b1;
            fire_road_d = road_idx_q;
            fire_cyc_d  = cyc_idx_q;
            if (road_idx_q < road_max_q) begin
              road_idx_d = road_idx_q + 1'b1;
            end else begin
              road_idx_d = '0;
              if (cyc_idx_q < cyc_max_q) begin
                cyc_idx_d = cyc_idx_q + 1'b1;
              end else begin
                done_d  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.b_p_busy       = (state_q == PRINT);
  assign bus.b_p_fire       = fire_q;
  assign bus.b_p_fire_road  = fire_road_q;
  assign bus.b_p_fire_cycle = fire_cyc_q;
  assign bus.b_p_done       = done_q;
  assign bus.b_p_bottle_cnt = cnt_q;
  assign bus.b_p_overrun    = overrun_q;

endmodule

// File: tb/tb_bottle_print.sv
// Directed bench for bottle_print: inputs change on falling edges, outputs sampled on falling edges.
module tb_bottle_print;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bottle_print_if bif ();

  bottle_print dut (
    .clk_100 (clk),
    .nRST    (rst_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic pulse_valid();
    @(negedge clk) bif.valid_edge_f1 = 1'b1;
    @(negedge clk) bif.valid_edge_f1 = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Eye low for 3 cycles; returns at the falling edge where busy is first expected high.
  task automatic eye_trigger();
    @(negedge clk) bif.dianyan_en = 1'b0;
    repeat (3) @(negedge clk);
    bif.dianyan_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.dianyan_en = 1'b1;
    bif.b_p_clr = 1'b0;
    bif.valid_edge_f1 = 1'b0;
    bif.b_p_road_num = 8'd6;
    bif.b_p_cycle_num = 8'd1;
    #23;
    total++; if (bif.b_p_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", bif.b_p_busy); end
    total++; if (bif.b_p_bottle_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bif.b_p_bottle_cnt); end
    total++; if ({bif.b_p_fire, bif.b_p_done, bif.b_p_overrun, bif.b_p_fire_road, bif.b_p_fire_cycle} !== 19'd0) begin
      bad++; $display("FAIL reset_outs got=%0h exp=0", {bif.b_p_fire, bif.b_p_done, bif.b_p_overrun, bif.b_p_fire_road, bif.b_p_fire_cycle});
    end
    @(negedge clk) rst_n = 1'b1;
    idle_gap(5);
    total++; if (bif.b_p_busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%0d exp=0", bif.b_p_busy); end
  endtask

  task automatic test_nominal();
    bif.b_p_road_num = 8'd6;
    bif.b_p_cycle_num = 8'd1;
    eye_trigger();
    total++; if (bif.b_p_busy !== 1'b1) begin bad++; $display("FAIL nom_trigger_latency busy got=%0d exp=1", bif.b_p_busy); end
    for (int i = 0; i < 6; i++) begin
      pulse_valid();
      total++; if (bif.b_p_fire !== 1'b1) begin bad++; $display("FAIL nom_fire%0d got=%0d exp=1", i, bif.b_p_fire); end
      total++; if (bif.b_p_fire_road !== 8'(i)) begin bad++; $display("FAIL nom_road%0d got=%0d exp=%0d", i, bif.b_p_fire_road, i); end
      total++; if (bif.b_p_fire_cycle !== 8'd0) begin bad++; $display("FAIL nom_cyc%0d got=%0d exp=0", i, bif.b_p_fire_cycle); end
      total++; if (bif.b_p_done !== (i == 5)) begin bad++; $display("FAIL nom_done%0d got=%0d exp=%0d", i, bif.b_p_done, (i == 5)); end
      if (i == 5) begin
        total++; if (bif.b_p_busy !== 1'b0) begin bad++; $display("FAIL nom_busy_fall got=%0d exp=0", bif.b_p_busy); end
      end
      idle_gap(1);
      total++; if (bif.b_p_fire !== 1'b0) begin bad++; $display("FAIL nom_fire_width%0d got=%0d exp=0", i, bif.b_p_fire); end
      idle_gap(18);
    end
    total++; if (bif.b_p_bottle_cnt !== 16'd1) begin bad++; $display("FAIL nom_cnt got=%0d exp=1", bif.b_p_bottle_cnt); end
    total++; if (bif.b_p_fire_road !== 8'd5) begin bad++; $display("FAIL nom_road_hold got=%0d exp=5", bif.b_p_fire_road); end
  endtask

  task automatic test_multi_cycle();
    bif.b_p_road_num = 8'd3;
    bif.b_p_cycle_num = 8'd2;
    eye_trigger();
    for (int i = 0; i < 6; i++) begin
      pulse_valid();
      total++; if ({bif.b_p_fire, bif.b_p_fire_road, bif.b_p_fire_cycle} !== {1'b1, 8'(i % 3), 8'(i / 3)}) begin
        bad++; $display("FAIL multi_fire%0d got=%0d/%0d/%0d exp=1/%0d/%0d", i, bif.b_p_fire, bif.b_p_fire_road, bif.b_p_fire_cycle, i % 3, i / 3);
      end
      total++; if (bif.b_p_done !== (i == 5)) begin bad++; $display("FAIL multi_done%0d got=%0d exp=%0d", i, bif.b_p_done, (i == 5)); end
      idle_gap(4);
    end
    total++; if (bif.b_p_bottle_cnt !== 16'd2) begin bad++; $display("FAIL multi_cnt got=%0d exp=2", bif.b_p_bottle_cnt); end
    total++; if (bif.b_p_busy !== 1'b0) begin bad++; $display("FAIL multi_busy got=%0d exp=0", bif.b_p_busy); end
  endtask

  task automatic test_zero_cfg();
    bif.b_p_road_num = 8'd0;
    bif.b_p_cycle_num = 8'd0;
    @(negedge clk) bif.dianyan_en = 1'b0;
    idle_gap(2);
    // Strobe sampled at the edge that enters PRINT: state was still IDLE, so ignored.
    bif.valid_edge_f1 = 1'b1;
    @(negedge clk) bif.valid_edge_f1 = 1'b0;
    bif.dianyan_en = 1'b1;
    total++; if (bif.b_p_fire !== 1'b0) begin bad++; $display("FAIL zero_idle_strobe fire got=%0d exp=0", bif.b_p_fire); end
    total++; if (bif.b_p_busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%0d exp=1", bif.b_p_busy); end
    pulse_valid();
    total++; if ({bif.b_p_fire, bif.b_p_done, bif.b_p_fire_road, bif.b_p_fire_cycle} !== {1'b1, 1'b1, 8'd0, 8'd0}) begin
      bad++; $display("FAIL zero_fire got=%0d/%0d/%0d/%0d exp=1/1/0/0", bif.b_p_fire, bif.b_p_done, bif.b_p_fire_road, bif.b_p_fire_cycle);
    end
    total++; if (bif.b_p_bottle_cnt !== 16'd3) begin bad++; $display("FAIL zero_cnt got=%0d exp=3", bif.b_p_bottle_cnt); end
    idle_gap(3);
  endtask

  task automatic test_idle_pulses();
    for (int i = 0; i < 3; i++) begin
      pulse_valid();
      total++; if (bif.b_p_fire !== 1'b0) begin bad++; $display("FAIL idle_fire%0d got=%0d exp=0", i, bif.b_p_fire); end
      total++; if (bif.b_p_busy !== 1'b0) begin bad++; $display("FAIL idle_busy%0d got=%0d exp=0", i, bif.b_p_busy); end
    end
    total++; if (bif.b_p_bottle_cnt !== 16'd3) begin bad++; $display("FAIL idle_cnt got=%0d exp=3", bif.b_p_bottle_cnt); end
  endtask

  task automatic test_overrun();
    bif.b_p_road_num = 8'd4;
    bif.b_p_cycle_num = 8'd1;
    eye_trigger();
    bif.b_p_road_num = 8'd2;
    pulse_valid();
    pulse_valid();
    @(negedge clk) bif.dianyan_en = 1'b0;
    idle_gap(5);
    bif.dianyan_en = 1'b1;
    idle_gap(4);
    total++; if (bif.b_p_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%0d exp=1", bif.b_p_overrun); end
    total++; if (bif.b_p_busy !== 1'b1) begin bad++; $display("FAIL ovr_busy got=%0d exp=1", bif.b_p_busy); end
    pulse_valid();
    total++; if ({bif.b_p_fire_road, bif.b_p_done} !== {8'd2, 1'b0}) begin
      bad++; $display("FAIL ovr_live_cfg road/done got=%0d/%0d exp=2/0", bif.b_p_fire_road, bif.b_p_done);
    end
    pulse_valid();
    total++; if ({bif.b_p_fire_road, bif.b_p_done} !== {8'd3, 1'b1}) begin
      bad++; $display("FAIL ovr_last road/done got=%0d/%0d exp=3/1", bif.b_p_fire_road, bif.b_p_done);
    end
    total++; if (bif.b_p_bottle_cnt !== 16'd4) begin bad++; $display("FAIL ovr_cnt got=%0d exp=4", bif.b_p_bottle_cnt); end
    idle_gap(3);
    total++; if (bif.b_p_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0d exp=1", bif.b_p_overrun); end
  endtask

  task automatic test_clear();
    bif.b_p_road_num = 8'd6;
    bif.b_p_cycle_num = 8'd1;
    eye_trigger();
    repeat (3) pulse_valid();
    @(negedge clk) bif.b_p_clr = 1'b1;
    @(negedge clk) bif.b_p_clr = 1'b0;
    total++; if (bif.b_p_busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%0d exp=0", bif.b_p_busy); end
    total++; if (bif.b_p_bottle_cnt !== 16'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", bif.b_p_bottle_cnt); end
    total++; if (bif.b_p_overrun !== 1'b0) begin bad++; $display("FAIL clr_overrun got=%0d exp=0", bif.b_p_overrun); end
    total++; if ({bif.b_p_fire_road, bif.b_p_fire_cycle, bif.b_p_done} !== 17'd0) begin
      bad++; $display("FAIL clr_outs got=%0h exp=0", {bif.b_p_fire_road, bif.b_p_fire_cycle, bif.b_p_done});
    end
    pulse_valid();
    total++; if (bif.b_p_fire !== 1'b0) begin bad++; $display("FAIL clr_no_fire got=%0d exp=0", bif.b_p_fire); end
    eye_trigger();
    pulse_valid();
    total++; if ({bif.b_p_fire, bif.b_p_fire_road} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL clr_restart got=%0d/%0d exp=1/0", bif.b_p_fire, bif.b_p_fire_road);
    end
    repeat (5) pulse_valid();
    total++; if ({bif.b_p_done, bif.b_p_bottle_cnt} !== {1'b1, 16'd1}) begin
      bad++; $display("FAIL clr_post_cnt done/cnt got=%0d/%0d exp=1/1", bif.b_p_done, bif.b_p_bottle_cnt);
    end
    idle_gap(3);
  endtask

  task automatic test_reset_mid();
    eye_trigger();
    repeat (2) pulse_valid();
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bif.b_p_busy, bif.b_p_fire, bif.b_p_fire_road, bif.b_p_bottle_cnt} !== 26'd0) begin
      bad++; $display("FAIL rstmid_outs got=%0h exp=0", {bif.b_p_busy, bif.b_p_fire, bif.b_p_fire_road, bif.b_p_bottle_cnt});
    end
    idle_gap(2);
    rst_n = 1'b1;
    idle_gap(5);
    total++; if (bif.b_p_busy !== 1'b0) begin bad++; $display("FAIL rstmid_no_trigger got=%0d exp=0", bif.b_p_busy); end
    pulse_valid();
    total++; if (bif.b_p_fire !== 1'b0) begin bad++; $display("FAIL rstmid_no_fire got=%0d exp=0", bif.b_p_fire); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_nominal();
    test_multi_cycle();
    test_zero_cfg();
    test_idle_pulses();
    test_overrun();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
